// File: rtl/proc_pkg.sv
// Shared definitions for the 9-bit processor fetch path: opcodes, sequencer states, word width.
package proc_pkg;

  localparam int DW_DEF = 9;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_I,
    S_LD_I,
    S_RD_M,
    S_LD_M,
    S_ISSUE,
    S_EXEC,
    S_HALTED
  } fetch_state_t;

  function automatic logic op_is_nop(input logic [2:0] op);
    return (op == 3'b100) || (op == 3'b101) || (op == 3'b110);
  endfunction

endpackage

// File: rtl/proc_fetch_ctrl_if.sv
// Program-ROM read port and processor DIN/Run/Done handshake, grouped as one bundle.
interface proc_fetch_ctrl_if #(
  parameter int AW = 5,
  parameter int DW = 9
);
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemData;
  logic [DW-1:0] DIN;
  logic          Run;
  logic          Done;

  modport master (output MemAddr, output DIN, output Run, input MemData, input Done);
  modport slave  (input MemAddr, input DIN, input Run, output MemData, output Done);
endinterface

// File: rtl/prog_counter.sv
// Program counter: synchronous load, increment enable, wraps modulo 2**AW.
module prog_counter #(
  parameter int AW = 5
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          i_load,
  input  logic [AW-1:0] i_load_val,
  input  logic          i_inc,
  output logic [AW-1:0] o_pc,
  output logic [AW-1:0] o_pc_next
);

  logic [AW-1:0] r_pc;

  // Next value is exported so the sequencer can register MemAddr in step with the PC.
  always_comb begin
    o_pc_next = r_pc;
    if (i_load)     o_pc_next = i_load_val;
    else if (i_inc) o_pc_next = r_pc + AW'(1);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) r_pc <= '0;
    else         r_pc <= o_pc_next;
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/proc_fetch_ctrl.sv
// Instruction sequencer: fetches from synchronous ROM, issues each instruction with a
// one-cycle Run pulse, and waits for Done (with timeout) before the next fetch.
module proc_fetch_ctrl
  import proc_pkg::*;
#(
  parameter int AW  = 5,
  parameter int DW  = DW_DEF,
  parameter int CW  = 8,
  parameter int TMO = 15
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Start,
  input  logic [AW-1:0] StartAddr,
  input  logic          HaltReq,
  proc_fetch_ctrl_if.master bus,
  output logic [AW-1:0] PC,
  output logic          Busy,
  output logic          Halted,
  output logic          Timeout,
  output logic [CW-1:0] Retired
);

  localparam int TW = $clog2(TMO + 1);

  fetch_state_t  r_state;
  logic [DW-1:0] r_instr;
  logic [DW-1:0] r_imm;
  logic [DW-1:0] r_din;
  logic          r_run;
  logic [AW-1:0] r_mem_addr;
  logic          r_busy;
  logic          r_halted;
  logic          r_timeout;
  logic          r_halt_pend;
  logic [CW-1:0] r_retired;
  logic [TW-1:0] r_tmo;

  logic          w_pc_load;
  logic          w_pc_inc;
  logic [AW-1:0] w_pc;
  logic [AW-1:0] w_pc_next;
  logic [2:0]    w_mem_op;
  logic [2:0]    w_instr_op;

  assign w_mem_op   = bus.MemData[DW-1 -: 3];
  assign w_instr_op = r_instr[DW-1 -: 3];

  always_comb begin
    w_pc_load = 1'b0;
    w_pc_inc  = 1'b0;
    case (r_state)
      S_IDLE, S_HALTED: w_pc_load = Start;
      S_LD_I:           w_pc_inc  = (w_mem_op != OP_HALT);
      S_LD_M:           w_pc_inc  = 1'b1;
      default: ;
    endcase
  end

  prog_counter #(.AW(AW)) u_pc (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .i_load     (w_pc_load),
    .i_load_val (StartAddr),
    .i_inc      (w_pc_inc),
    .o_pc       (w_pc),
    .o_pc_next  (w_pc_next)
  );

  // MemAddr is loaded on entry to RD_I/RD_M with the PC value that state will hold,
  // so it equals PC throughout the read state and holds elsewhere.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state     <= S_IDLE;
      r_instr     <= '0;
      r_imm       <= '0;
      r_din       <= '0;
      r_run       <= 1'b0;
      r_mem_addr  <= '0;
      r_busy      <= 1'b0;
      r_halted    <= 1'b0;
      r_timeout   <= 1'b0;
      r_halt_pend <= 1'b0;
      r_retired   <= '0;
      r_tmo       <= '0;
    end else begin
      if (r_busy && HaltReq) r_halt_pend <= 1'b1;
      case (r_state)
        S_IDLE, S_HALTED: begin
          if (Start) begin
            r_state     <= S_RD_I;
            r_mem_addr  <= w_pc_next;
            r_busy      <= 1'b1;
            r_halted    <= 1'b0;
            r_timeout   <= 1'b0;
            r_halt_pend <= 1'b0;
          end
        end
        S_RD_I: r_state <= S_LD_I;
        S_LD_I: begin
          r_instr <= bus.MemData;
          if (w_mem_op == OP_HALT) begin
            r_state     <= S_HALTED;
            r_busy      <= 1'b0;
            r_halted    <= 1'b1;
            r_halt_pend <= 1'b0;
          end else if (op_is_nop(w_mem_op)) begin
            r_state    <= S_RD_I;
            r_mem_addr <= w_pc_next;
          end else if (w_mem_op == OP_MVI) begin
            r_state    <= S_RD_M;
            r_mem_addr <= w_pc_next;
          end else begin
            r_state <= S_ISSUE;
            r_din   <= bus.MemData;
            r_run   <= 1'b1;
          end
        end
        S_RD_M: r_state <= S_LD_M;
        S_LD_M: begin
          r_imm   <= bus.MemData;
          r_state <= S_ISSUE;
          r_din   <= r_instr;
          r_run   <= 1'b1;
        end
        S_ISSUE: begin
          r_state <= S_EXEC;
          r_run   <= 1'b0;
          r_tmo   <= '0;
          r_din   <= (w_instr_op == OP_MVI) ? r_imm : r_instr;
        end
        S_EXEC: begin
          if (bus.Done) begin
            r_retired <= r_retired + CW'(1);
            if (r_halt_pend || HaltReq) begin
              r_state     <= S_HALTED;
              r_busy      <= 1'b0;
              r_halted    <= 1'b1;
              r_halt_pend <= 1'b0;
            end else begin
              r_state    <= S_RD_I;
              r_mem_addr <= w_pc;
            end
          end else if (r_tmo == TW'(TMO - 1)) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_timeout   <= 1'b1;
            r_halt_pend <= 1'b0;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.MemAddr = r_mem_addr;
  assign bus.DIN     = r_din;
  assign bus.Run     = r_run;
  assign PC          = w_pc;
  assign Busy        = r_busy;
  assign Halted      = r_halted;
  assign Timeout     = r_timeout;
  assign Retired     = r_retired;

endmodule

// File: tb/tb_proc_fetch_ctrl.sv
// Bench for proc_fetch_ctrl: ROM and processor stub around the DUT, program-walking reference model.
module tb_proc_fetch_ctrl;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b1;
  logic       Start = 1'b0;
  logic [4:0] StartAddr = '0;
  logic       HaltReq = 1'b0;
  logic [4:0] PC;
  logic       Busy, Halted, Timeout;
  logic [7:0] Retired;

  proc_fetch_ctrl_if #(.AW(5), .DW(9)) bus();

  proc_fetch_ctrl #(.AW(5), .DW(9), .CW(8), .TMO(15)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Start     (Start),
    .StartAddr (StartAddr),
    .HaltReq   (HaltReq),
    .bus       (bus),
    .PC        (PC),
    .Busy      (Busy),
    .Halted    (Halted),
    .Timeout   (Timeout),
    .Retired   (Retired)
  );

  always #5 Clock = ~Clock;

  logic [8:0] rom [32];
  always @(posedge Clock) bus.MemData <= rom[bus.MemAddr];

  // Processor stub: mv/mvi finish in the first EXEC cycle, add/sub in the third.
  logic [8:0] R [8];
  logic [8:0] ir;
  int         cnt;
  logic       mute = 1'b0;
  logic       spur = 1'b0;
  assign bus.Done = (cnt == 1) || spur;

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt <= 0;
      ir  <= '0;
      for (int i = 0; i < 8; i++) R[i] <= '0;
    end else begin
      if (cnt == 1) begin
        case (ir[8:6])
          3'b000: R[ir[5:3]] <= R[ir[2:0]];
          3'b001: R[ir[5:3]] <= bus.DIN;
          3'b010: R[ir[5:3]] <= R[ir[5:3]] + R[ir[2:0]];
          3'b011: R[ir[5:3]] <= R[ir[5:3]] - R[ir[2:0]];
          default: ;
        endcase
      end
      if (cnt > 0) cnt <= cnt - 1;
      if (bus.Run && !mute) begin
        ir  <= bus.DIN;
        cnt <= (bus.DIN[8:7] == 2'b00) ? 1 : 3;
      end
    end
  end

  logic [8:0] obs_run[$], obs_exec[$];
  logic       prev_run = 1'b0;
  always @(negedge Clock) begin
    if (prev_run) obs_exec.push_back(bus.DIN);
    if (bus.Run)  obs_run.push_back(bus.DIN);
    prev_run = bus.Run;
  end

  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [8:0] exp_run[$], exp_exec[$];
  logic [8:0] M [8];
  logic [7:0] exp_retired = '0;

  // Walks the program as the architecture defines it: each word costs a read and a load
  // cycle, issued instructions add an issue cycle plus their execution time.
  task automatic model_run(input logic [4:0] start, output int edges, output logic [4:0] pc_end);
    logic [4:0] pc;
    logic [8:0] w, imm;
    logic [2:0] op, x, y;
    pc = start;
    edges = 0;
    exp_run.delete();
    exp_exec.delete();
    for (int g = 0; g < 64; g++) begin
      w = rom[pc]; op = w[8:6]; x = w[5:3]; y = w[2:0];
      edges += 2;
      if (op == 3'b111) break;
      pc = pc + 5'd1;
      if (op >= 3'b100) continue;
      imm = w;
      if (op == 3'b001) begin
        imm = rom[pc];
        pc = pc + 5'd1;
        edges += 2;
      end
      edges += (op == 3'b010 || op == 3'b011) ? 4 : 2;
      exp_run.push_back(w);
      exp_exec.push_back(imm);
      case (op)
        3'b000: M[x] = M[y];
        3'b001: M[x] = imm;
        3'b010: M[x] = M[x] + M[y];
        default: M[x] = M[x] - M[y];
      endcase
      exp_retired++;
    end
    pc_end = pc;
  endtask

  task automatic run_prog(input string tag, input logic [4:0] start, input bit poke);
    int         exp_edges, n;
    logic [4:0] exp_pc;
    logic [71:0] got, want;
    for (int i = 0; i < 8; i++) M[i] = R[i];
    model_run(start, exp_edges, exp_pc);
    @(negedge Clock);
    obs_run.delete();
    obs_exec.delete();
    StartAddr = start;
    Start = 1'b1;
    @(posedge Clock);
    #1;
    HaltReq = 1'b0;
    Start = poke;
    spur = poke;
    StartAddr = 5'($urandom);
    n = 0;
    while (n < 300) begin
      @(posedge Clock);
      n++;
      #1;
      if (n == 1) begin
        Start = 1'b0;
        spur = 1'b0;
      end
      if (Halted) break;
    end
    check({tag, ".halted"}, 72'(Halted), 72'(1));
    check({tag, ".cycles"}, 72'(n), 72'(exp_edges));
    check({tag, ".pc"}, 72'(PC), 72'(exp_pc));
    check({tag, ".memaddr"}, 72'(bus.MemAddr), 72'(exp_pc));
    check({tag, ".busy"}, 72'(Busy), 72'(0));
    check({tag, ".timeout"}, 72'(Timeout), 72'(0));
    check({tag, ".retired"}, 72'(Retired), 72'(exp_retired));
    check({tag, ".runs"}, 72'(obs_run.size()), 72'(exp_run.size()));
    for (int i = 0; i < exp_run.size(); i++) begin
      check({tag, ".din_run"}, (i < obs_run.size()) ? 72'(obs_run[i]) : 'x, 72'(exp_run[i]));
      check({tag, ".din_exec"}, (i < obs_exec.size()) ? 72'(obs_exec[i]) : 'x, 72'(exp_exec[i]));
    end
    for (int i = 0; i < 8; i++) begin
      got[i*9 +: 9]  = R[i];
      want[i*9 +: 9] = M[i];
    end
    check({tag, ".regs"}, got, want);
  endtask

  initial begin
    int n;
    logic [4:0] p, st;
    logic [2:0] op;
    logic [8:0] r0exp;

    for (int i = 0; i < 32; i++) rom[i] = 9'o700;
    #2 Resetn = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check("rst.pc", 72'(PC), 72'(0));
    check("rst.memaddr", 72'(bus.MemAddr), 72'(0));
    check("rst.din", 72'(bus.DIN), 72'(0));
    check("rst.run", 72'(bus.Run), 72'(0));
    check("rst.busy", 72'(Busy), 72'(0));
    check("rst.halted", 72'(Halted), 72'(0));
    check("rst.timeout", 72'(Timeout), 72'(0));
    check("rst.retired", 72'(Retired), 72'(0));
    @(negedge Clock);
    Resetn = 1'b1;
    exp_retired = '0;

    rom[0] = 9'o100; rom[1] = 9'd5; rom[2] = 9'o700;
    run_prog("mvi", 5'd0, 1'b0);
    check("mvi.r0", 72'(R[0]), 72'(5));

    // HaltReq presented with Start in HALTED must be dropped.
    rom[2] = 9'o010; rom[3] = 9'o201; rom[4] = 9'o700;
    HaltReq = 1'b1;
    run_prog("mvadd", 5'd0, 1'b0);
    check("mvadd.r0", 72'(R[0]), 72'(10));

    rom[31] = 9'o010; rom[0] = 9'o700;
    run_prog("wrap", 5'd31, 1'b0);

    rom[0] = 9'b100_000_000; rom[1] = 9'o700;
    run_prog("nop", 5'd0, 1'b0);

    rom[0] = 9'o010;
    mute = 1'b1;
    @(negedge Clock);
    obs_run.delete();
    StartAddr = 5'd0;
    Start = 1'b1;
    @(posedge Clock);
    #1 Start = 1'b0;
    n = 0;
    while (n < 100) begin
      @(posedge Clock);
      n++;
      #1;
      if (Timeout) break;
    end
    repeat (5) @(posedge Clock);
    #1;
    check("tmo.cycles", 72'(n), 72'(18));
    check("tmo.flag", 72'(Timeout), 72'(1));
    check("tmo.busy", 72'(Busy), 72'(0));
    check("tmo.halted", 72'(Halted), 72'(0));
    check("tmo.runs", 72'(obs_run.size()), 72'(1));
    check("tmo.retired", 72'(Retired), 72'(exp_retired));
    mute = 1'b0;

    rom[0] = 9'o201; rom[1] = 9'o010; rom[2] = 9'o700;
    r0exp = R[0] + R[1];
    @(negedge Clock);
    obs_run.delete();
    StartAddr = 5'd0;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    n = 0;
    while (!bus.Run && n < 20) begin
      @(negedge Clock);
      n++;
    end
    @(negedge Clock);
    HaltReq = 1'b1;
    @(negedge Clock);
    HaltReq = 1'b0;
    n = 0;
    while (!Halted && n < 20) begin
      @(negedge Clock);
      n++;
    end
    exp_retired++;
    repeat (4) @(negedge Clock);
    check("hreq.halted", 72'(Halted), 72'(1));
    check("hreq.retired", 72'(Retired), 72'(exp_retired));
    check("hreq.pc", 72'(PC), 72'(1));
    check("hreq.runs", 72'(obs_run.size()), 72'(1));
    check("hreq.r0", 72'(R[0]), 72'(r0exp));

    rom[0] = 9'o100; rom[1] = 9'o123; rom[2] = 9'o700; rom[4] = 9'o700;
    @(negedge Clock);
    StartAddr = 5'd0;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    n = 0;
    while (!bus.Run && n < 20) begin
      @(negedge Clock);
      n++;
    end
    @(negedge Clock);
    Resetn = 1'b0;
    #1;
    check("amid.run", 72'(bus.Run), 72'(0));
    check("amid.din", 72'(bus.DIN), 72'(0));
    check("amid.pc", 72'(PC), 72'(0));
    check("amid.busy", 72'(Busy), 72'(0));
    check("amid.retired", 72'(Retired), 72'(0));
    exp_retired = '0;
    @(negedge Clock);
    Resetn = 1'b1;
    run_prog("restart4", 5'd4, 1'b0);

    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < 32; i++) rom[i] = 9'o700;
      st = 5'($urandom);
      p = st;
      for (int j = 0; j < int'($urandom_range(0, 8)); j++) begin
        op = 3'($urandom_range(0, 6));
        rom[p] = {op, 6'($urandom)};
        p = p + 5'd1;
        if (op == 3'b001) begin
          rom[p] = 9'($urandom);
          p = p + 5'd1;
        end
      end
      rom[p] = 9'o700;
      run_prog("rnd", st, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
